// File: rtl/vpm_pkg.sv
// Shared definitions for the video palette mux.
//   ld_state_e    : palette loader states (idle, then one state per byte of an entry)
//   BytesPerEntry : host bytes per palette entry ({R,G,B})
//   clog2_min1    : clog2 that never returns 0, so 1-entry selectors still get a 1-bit port
package vpm_pkg;

  typedef enum logic [1:0] {StIdle, StB0, StB1, StB2} ld_state_e;

  localparam int unsigned BytesPerEntry = 3;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pal_dpram.sv
// Palette storage: simple dual-port RAM, one write port and one read port.
//   clk   : clock
//   we    : write enable; waddr/wdata written on the rising edge
//   raddr : read address; rdata valid the cycle after raddr is presented
// A read and write to the same address in one cycle returns the old data.
// Contents are never reset.
module pal_dpram
  import vpm_pkg::*;
#(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned WIDTH  = 24
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/video_palette_mux.sv
// Multi-source palette video mux.
//   clk_sys, reset_n        : system clock, async active-low reset
//   src_idx                 : packed per-source palette indices (source 0 in LSBs)
//   src_h/vblank, h/vsync   : per-source timing; src_pix_ce per-source pixel strobe
//   sel, bank_sel           : requested source / display bank, taken at active vsync rise
//   blend                   : horizontal 2-pixel averaging
//   pal_load/wr/data/bank   : byte-wise palette loader (R, G, B per entry)
//   red/green/blue, timing  : registered video out, 2 cycles after the source pixel
//   sel_active, load_done   : displayed source; pulse when a whole bank has been written
module video_palette_mux
  import vpm_pkg::*;
#(
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned IDX_W     = 8,
  parameter int unsigned CH_W      = 8,
  parameter int unsigned NUM_BANKS = 4,
  localparam int unsigned SEL_W    = clog2_min1(NUM_SRC),
  localparam int unsigned BANK_W   = clog2_min1(NUM_BANKS)
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic [NUM_SRC*IDX_W-1:0] src_idx,
  input  logic [NUM_SRC-1:0]       src_hblank,
  input  logic [NUM_SRC-1:0]       src_vblank,
  input  logic [NUM_SRC-1:0]       src_hsync,
  input  logic [NUM_SRC-1:0]       src_vsync,
  input  logic [NUM_SRC-1:0]       src_pix_ce,
  input  logic [SEL_W-1:0]         sel,
  input  logic [BANK_W-1:0]        bank_sel,
  input  logic                     blend,
  input  logic                     pal_load,
  input  logic                     pal_wr,
  input  logic [7:0]               pal_data,
  input  logic [BANK_W-1:0]        pal_bank,
  output logic [CH_W-1:0]          red,
  output logic [CH_W-1:0]          green,
  output logic [CH_W-1:0]          blue,
  output logic                     hblank,
  output logic                     vblank,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     pix_ce,
  output logic [SEL_W-1:0]         sel_active,
  output logic                     load_done
);

  localparam int unsigned ENTRY_W = BytesPerEntry * CH_W;
  localparam int unsigned ADDR_W  = BANK_W + IDX_W;
  localparam int unsigned DEPTH   = NUM_BANKS << IDX_W;

  // ---------------------------------------------------------------------------
  // Active-source selection
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0]  sel_q;
  logic [BANK_W-1:0] bank_q;
  logic              vs_prev_q;
  logic [IDX_W-1:0]  cur_idx;
  logic              cur_hb, cur_vb, cur_hs, cur_vs, cur_ce, new_vs, vs_rise;

  always_comb begin
    cur_idx = '0;
    cur_hb  = 1'b0;
    cur_vb  = 1'b0;
    cur_hs  = 1'b0;
    cur_vs  = 1'b0;
    cur_ce  = 1'b0;
    new_vs  = 1'b0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (sel_q == SEL_W'(s)) begin
        cur_idx = src_idx[s*IDX_W +: IDX_W];
        cur_hb  = src_hblank[s];
        cur_vb  = src_vblank[s];
        cur_hs  = src_hsync[s];
        cur_vs  = src_vsync[s];
        cur_ce  = src_pix_ce[s];
      end
      if (sel == SEL_W'(s)) begin
        new_vs = src_vsync[s];
      end
    end
  end

  assign vs_rise    = cur_vs & ~vs_prev_q;
  assign sel_active = sel_q;

  // Set while no pixel has been shown since the line (or source) started; the
  // next pixel then blends with itself instead of the stale previous entry.
  logic line_start_q, line_start_d;

  always_comb begin
    line_start_d = line_start_q;
    if (cur_hb) begin
      line_start_d = 1'b1;
    end else if (cur_ce) begin
      line_start_d = 1'b0;
    end
    if (vs_rise && (sel != sel_q)) begin
      line_start_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Loader
  // ---------------------------------------------------------------------------
  ld_state_e         state_q, state_d;
  logic [IDX_W-1:0]  addr_q, addr_d;
  logic [BANK_W-1:0] wbank_q, wbank_d;
  logic [CH_W-1:0]   r_q, r_d, g_q, g_d, byte_ch;
  logic              load_prev_q, done_q, done_d, we;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wbank_d = wbank_q;
    r_d     = r_q;
    g_d     = g_q;
    we      = 1'b0;
    done_d  = 1'b0;
    byte_ch = pal_data[7 -: CH_W];
    if (!pal_load) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!load_prev_q) begin
            state_d = StB0;
            addr_d  = '0;
            wbank_d = pal_bank;
          end
        end
        StB0: begin
          if (pal_wr) begin
            r_d     = byte_ch;
            state_d = StB1;
          end
        end
        StB1: begin
          if (pal_wr) begin
            g_d     = byte_ch;
            state_d = StB2;
          end
        end
        StB2: begin
          if (pal_wr) begin
            we      = 1'b1;
            addr_d  = addr_q + 1'b1;  // wraps to 0 after the last entry
            done_d  = &addr_q;
            state_d = StB0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign load_done = done_q;

  // ---------------------------------------------------------------------------
  // Palette RAM
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] rd_data;

  pal_dpram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (ENTRY_W)
  ) u_pal (
    .clk   (clk_sys),
    .we    (we),
    .waddr ({wbank_q, addr_q}),
    .wdata ({r_q, g_q, byte_ch}),
    .raddr ({bank_q, cur_idx}),
    .rdata (rd_data)
  );

  // ---------------------------------------------------------------------------
  // Pixel pipeline: stage 1 sees RAM data, stage 2 is the output register
  // ---------------------------------------------------------------------------
  logic               ce_s1_q, first_s1_q, blend_s1_q;
  logic [3:0]         tim_s1_q, tim_q;
  logic [ENTRY_W-1:0] prev_q, rgb_q, pix_d;
  logic               ce_q;
  logic [CH_W:0]      sum;

  always_comb begin
    pix_d = rd_data;
    sum   = '0;
    if (blend_s1_q && !first_s1_q) begin
      for (int unsigned c = 0; c < BytesPerEntry; c++) begin
        sum = {1'b0, prev_q[c*CH_W +: CH_W]} + {1'b0, rd_data[c*CH_W +: CH_W]};
        pix_d[c*CH_W +: CH_W] = sum[CH_W:1];
      end
    end
  end

  assign red    = rgb_q[2*CH_W +: CH_W];
  assign green  = rgb_q[CH_W +: CH_W];
  assign blue   = rgb_q[0 +: CH_W];
  assign hblank = tim_q[3];
  assign vblank = tim_q[2];
  assign hsync  = tim_q[1];
  assign vsync  = tim_q[0];
  assign pix_ce = ce_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sel_q        <= '0;
      bank_q       <= '0;
      vs_prev_q    <= 1'b0;
      line_start_q <= 1'b1;
      state_q      <= StIdle;
      addr_q       <= '0;
      wbank_q      <= '0;
      r_q          <= '0;
      g_q          <= '0;
      // Treat pal_load as already high so a level held through reset is not a new session.
      load_prev_q  <= 1'b1;
      done_q       <= 1'b0;
      ce_s1_q      <= 1'b0;
      first_s1_q   <= 1'b1;
      blend_s1_q   <= 1'b0;
      tim_s1_q     <= '0;
      prev_q       <= '0;
      rgb_q        <= '0;
      tim_q        <= '0;
      ce_q         <= 1'b0;
    end else begin
      if (vs_rise) begin
        sel_q     <= sel;
        bank_q    <= bank_sel;
        vs_prev_q <= new_vs;  // track the incoming source's vsync from now on
      end else begin
        vs_prev_q <= cur_vs;
      end
      line_start_q <= line_start_d;
      state_q      <= state_d;
      addr_q       <= addr_d;
      wbank_q      <= wbank_d;
      r_q          <= r_d;
      g_q          <= g_d;
      load_prev_q  <= pal_load;
      done_q       <= done_d;
      ce_s1_q      <= cur_ce;
      tim_s1_q     <= {cur_hb, cur_vb, cur_hs, cur_vs};
      if (cur_ce) begin
        first_s1_q <= line_start_q | cur_hb;
        blend_s1_q <= blend;
      end
      if (ce_s1_q) begin
        rgb_q  <= pix_d;
        prev_q <= rd_data;
      end
      ce_q  <= ce_s1_q;
      tim_q <= tim_s1_q;
    end
  end

endmodule

// File: tb/tb_video_palette_mux.sv
module tb_video_palette_mux;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [15:0] src_idx;
  logic [1:0]  src_hblank, src_vblank, src_hsync, src_vsync, src_pix_ce;
  logic        sel;
  logic [1:0]  bank_sel;
  logic        blend, pal_load, pal_wr;
  logic [7:0]  pal_data;
  logic [1:0]  pal_bank;
  logic [7:0]  red, green, blue;
  logic        hblank, vblank, hsync, vsync, pix_ce;
  logic        sel_active, load_done;

  video_palette_mux dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .src_idx    (src_idx),
    .src_hblank (src_hblank),
    .src_vblank (src_vblank),
    .src_hsync  (src_hsync),
    .src_vsync  (src_vsync),
    .src_pix_ce (src_pix_ce),
    .sel        (sel),
    .bank_sel   (bank_sel),
    .blend      (blend),
    .pal_load   (pal_load),
    .pal_wr     (pal_wr),
    .pal_data   (pal_data),
    .pal_bank   (pal_bank),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .hblank     (hblank),
    .vblank     (vblank),
    .hsync      (hsync),
    .vsync      (vsync),
    .pix_ce     (pix_ce),
    .sel_active (sel_active),
    .load_done  (load_done)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int ld_cnt   = 0;
  int ld_cyc   = -1;
  int last_wr  = 0;

  typedef struct {
    int          due;
    logic [23:0] rgb;
  } exp_t;
  exp_t sb[$];
  exp_t got;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard side: every output pixel must be pending, on time and the right colour.
  always @(negedge clk_sys) begin
    if (reset_n && pix_ce) begin
      check("pix_pending", {31'b0, sb.size() > 0}, 32'd1);
      if (sb.size() > 0) begin
        got = sb.pop_front();
        check("pix_cycle", cyc, got.due);
        check("pix_rgb", {8'h0, red, green, blue}, {8'h0, got.rgb});
      end
    end
    if (load_done) begin
      ld_cnt++;
      ld_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_load(input logic [1:0] bank);
    pal_load = 1'b0;
    tick();
    pal_bank = bank;
    pal_load = 1'b1;
    tick();
  endtask

  task automatic wr_byte(input logic [7:0] b);
    pal_data = b;
    pal_wr   = 1'b1;
    tick();
    pal_wr   = 1'b0;
  endtask

  task automatic wr_entry(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    wr_byte(r);
    wr_byte(g);
    wr_byte(b);
  endtask

  task automatic pix(input int src, input logic [7:0] idx, input logic [23:0] rgb);
    src_idx[src*8 +: 8] = idx;
    src_pix_ce[src]     = 1'b1;
    sb.push_back('{cyc + 2, rgb});
    tick();
    src_pix_ce[src] = 1'b0;
  endtask

  task automatic vsync_pulse(input int src);
    src_vsync[src] = 1'b1;
    tick();
    src_vsync[src] = 1'b0;
    tick();
  endtask

  initial begin
    src_idx = '0; src_hblank = '0; src_vblank = '0; src_hsync = '0; src_vsync = '0;
    src_pix_ce = '0; sel = 1'b0; bank_sel = '0; blend = 1'b0;
    pal_load = 1'b0; pal_wr = 1'b0; pal_data = '0; pal_bank = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("reset_outputs", {1'b0, red, green, blue, hblank, vblank, hsync, vsync, pix_ce,
                            load_done, sel_active}, 32'd0);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Bank 1 entries 0..5, entry 5 = FF 80 01; bank 2 entries 0/1 = grey 10 / 21
    start_load(2'd1);
    for (int i = 0; i < 5; i++) wr_entry(8'h00, 8'h00, 8'h00);
    wr_entry(8'hFF, 8'h80, 8'h01);
    start_load(2'd2);
    wr_entry(8'h10, 8'h10, 8'h10);
    wr_entry(8'h21, 8'h21, 8'h21);
    pal_load = 1'b0;

    // Basic lookup through bank 1
    bank_sel = 2'd1;
    vsync_pulse(0);
    check("sel_after_vsync", {31'b0, sel_active}, 32'd0);
    pix(0, 8'h05, 24'hFF8001);
    tick();
    tick();

    // Timing signals follow with the same 2-cycle delay
    src_hsync[0]  = 1'b1;
    src_vblank[0] = 1'b1;
    tick();
    src_hsync[0]  = 1'b0;
    src_vblank[0] = 1'b0;
    check("hsync_t1", {31'b0, hsync}, 32'd0);
    tick();
    check("hsync_t2", {30'b0, hsync, vblank}, 32'd3);
    tick();
    check("hsync_t3", {30'b0, hsync, vblank}, 32'd0);

    // Pixel coincident with vsync rise uses the old bank
    bank_sel = 2'd2;
    src_vsync[0] = 1'b1;
    pix(0, 8'h05, 24'hFF8001);
    src_vsync[0] = 1'b0;
    tick();
    pix(0, 8'h00, 24'h101010);

    // Blend: first pixel after hblank shows itself, next averages
    blend = 1'b1;
    src_hblank[0] = 1'b1;
    tick();
    src_hblank[0] = 1'b0;
    pix(0, 8'h00, 24'h101010);
    pix(0, 8'h01, 24'h181818);
    src_hblank[0] = 1'b1;
    tick();
    src_hblank[0] = 1'b0;
    pix(0, 8'h00, 24'h101010);
    pix(0, 8'h01, 24'h181818);
    blend = 1'b0;
    tick();

    // Full bank fill with wrap, then a partial entry and stray writes
    ld_cnt = 0;
    start_load(2'd3);
    for (int i = 0; i < 256; i++) wr_entry(8'(i), 8'(i) ^ 8'hFF, 8'(i + 1));
    last_wr = cyc;
    tick();
    check("load_done_count", ld_cnt, 32'd1);
    check("load_done_cycle", ld_cyc, last_wr);
    wr_entry(8'hAA, 8'hBB, 8'hCC);
    wr_byte(8'hDD);
    wr_byte(8'hEE);
    pal_load = 1'b0;
    tick();
    wr_entry(8'h77, 8'h77, 8'h77);
    tick();
    check("load_done_once", ld_cnt, 32'd1);
    bank_sel = 2'd3;
    vsync_pulse(0);
    pix(0, 8'h00, 24'hAABBCC);
    pix(0, 8'h01, 24'h01FE02);
    pix(0, 8'hFF, 24'hFF0000);
    tick();

    // Source switch waits for the old source's vsync
    sel = 1'b1;
    src_idx[15:8] = 8'h00;
    pix(0, 8'h01, 24'h01FE02);
    check("sel_hold_1", {31'b0, sel_active}, 32'd0);
    src_hsync[1] = 1'b1;
    tick();
    src_hsync[1] = 1'b0;
    tick();
    check("other_hsync_ignored", {31'b0, hsync}, 32'd0);
    vsync_pulse(1);
    check("sel_hold_2", {31'b0, sel_active}, 32'd0);
    pix(0, 8'h01, 24'h01FE02);
    vsync_pulse(0);
    check("sel_switched", {31'b0, sel_active}, 32'd1);
    pix(1, 8'h00, 24'hAABBCC);
    tick();
    tick();

    // Reset in loader state B1 with a pixel in flight
    start_load(2'd2);
    wr_byte(8'h99);
    src_pix_ce[1] = 1'b1;
    tick();
    src_pix_ce[1] = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("midreset_outputs", {1'b0, red, green, blue, hblank, vblank, hsync, vsync, pix_ce,
                               load_done, sel_active}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("sel_after_reset", {31'b0, sel_active}, 32'd0);
    wr_entry(8'h11, 8'h22, 8'h33);
    pal_load = 1'b0;
    sel = 1'b0;
    bank_sel = 2'd2;
    vsync_pulse(0);
    pix(0, 8'h00, 24'h101010);
    start_load(2'd2);
    wr_entry(8'h44, 8'h55, 8'h66);
    pal_load = 1'b0;
    tick();
    pix(0, 8'h00, 24'h445566);
    repeat (4) tick();
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
